usr_burst: RTL and testbench

Parametrised universal shift/rotate register, N bits wide. It extends the basic hold/shift/load register with rotate, arithmetic-shift-right and clear modes. It adds a burst engine that, from a single start strobe, performs a programmed number of shift or rotate steps and reports busy and done. It sits in the datapath wherever serialisation, barrel-style stepping or multi-step alignment is needed.

---
 rtl/usr_burst.sv | 123 ++++++++++++
 tb/tb_usr_burst.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_burst.sv
// usr_burst: N-bit universal shift/rotate register with a burst engine.
// Direct ops apply every cycle in IDLE. A valid start latches a step-class
// op and a count, then runs that op once per cycle until the count is used up.
//
// Handshake: start is a one-cycle request sampled only in IDLE. It is accepted
// when count != 0 and mode is step-class. Acceptance is visible as busy=1 from
// the following cycle. Completion is the single-cycle done pulse that follows
// the last step. In that cycle the block is back in IDLE and can accept a new
// start immediately.
module usr_burst #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    mode,
    input  logic [N-1:0]  p_data,
    input  logic          sin_left,
    input  logic          sin_right,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic [N-1:0]  Q,
    output logic          sout_left,
    output logic          sout_right,
    output logic          busy,
    output logic          done,
    output logic          dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] remaining;
    logic [2:0]    burst_mode;
    logic          step_class;
    logic          start_ok;
    logic [N-1:0]  direct_next;
    logic [N-1:0]  burst_next;

    // Next register value for a given op; hold and unknown ops keep q.
    function automatic logic [N-1:0] apply_op(
        input logic [2:0]   op,
        input logic [N-1:0] q,
        input logic [N-1:0] pd,
        input logic         sl,
        input logic         sr
    );
        logic [N-1:0] r;
        r = q;
        case (op)
            3'b001:  r = {sl, q[N-1:1]};
            3'b010:  r = {q[N-2:0], sr};
            3'b011:  r = pd;
            3'b100:  r = {q[0], q[N-1:1]};
            3'b101:  r = {q[N-2:0], q[N-1]};
            3'b110:  r = {q[N-1], q[N-1:1]};
            3'b111:  r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

    // Classify the live mode and compute both candidate next values.
    always_comb begin
        step_class = 1'b0;
        case (mode)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: step_class = 1'b1;
            default:                                step_class = 1'b0;
        endcase
        start_ok    = start && (count != '0) && step_class;
        direct_next = apply_op(mode, Q, p_data, sin_left, sin_right);
        burst_next  = apply_op(burst_mode, Q, p_data, sin_left, sin_right);
    end

    assign sout_left  = Q[N-1];
    assign sout_right = Q[0];
    assign dbg_state  = state;

    // Burst FSM together with the register and its registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            Q          <= '0;
            remaining  <= '0;
            burst_mode <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        // E0: latch the burst and hold Q; stepping starts next edge.
                        burst_mode <= mode;
                        remaining  <= count;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else begin
                        Q <= direct_next;
                    end
                end
                RUN: begin
                    Q         <= burst_next;
                    remaining <= remaining - 1'b1;
                    if (remaining == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_burst.sv
// Bench for usr_burst: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model built from the op table.
module tb_usr_burst;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [2:0]    mode;
    logic [N-1:0]  p_data;
    logic          sin_left;
    logic          sin_right;
    logic          start;
    logic [CW-1:0] count;
    logic [N-1:0]  Q;
    logic          sout_left;
    logic          sout_right;
    logic          busy;
    logic          done;
    logic          dbg_state;

    int total;
    int bad;

    // Model state: value, steps still to run, latched op, flags.
    int   m_q;
    int   m_left;
    int   m_op;
    logic m_busy;
    logic m_done;

    usr_burst #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .p_data(p_data),
        .sin_left(sin_left), .sin_right(sin_right), .start(start), .count(count),
        .Q(Q), .sout_left(sout_left), .sout_right(sout_right),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference op semantics written with integer arithmetic.
    function automatic int model_op(input int op, input int q, input int pd, input int sl, input int sr);
        case (op)
            1:       return (q / 2) + sl * 128;
            2:       return ((q * 2) % 256) + sr;
            3:       return pd;
            4:       return (q / 2) + (q % 2) * 128;
            5:       return ((q * 2) % 256) + (q / 128);
            6:       return (q / 2) + ((q >= 128) ? 128 : 0);
            7:       return 0;
            default: return q;
        endcase
    endfunction

    function automatic bit is_step(input int op);
        return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
    endfunction

    task automatic model_reset();
        m_q = 0; m_left = 0; m_op = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    // Driver: advance one clock, update the model from the sampled inputs,
    // then move 1 time unit past the edge so outputs are stable for checking.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (m_left > 0) begin
            m_q = model_op(m_op, m_q, p_data, sin_left, sin_right);
            m_left = m_left - 1;
            m_done = (m_left == 0);
            m_busy = (m_left != 0);
        end else begin
            m_done = 1'b0;
            if (start && count != 0 && is_step(mode)) begin
                m_op = mode; m_left = count; m_busy = 1'b1;
            end else begin
                m_q = model_op(mode, m_q, p_data, sin_left, sin_right);
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        mode = 3'b000; p_data = '0; sin_left = 1'b0; sin_right = 1'b0;
        start = 1'b0; count = '0;
    endtask

    task automatic load(input logic [N-1:0] v);
        drive_idle(); mode = 3'b011; p_data = v; tick(); drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0; model_reset();
        #3;
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", Q); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
        tick(); tick();
        total++; if (Q !== 8'h00 || dbg_state !== 1'b0) begin bad++; $display("FAIL reset_hold: q=%h st=%b want 00 0", Q, dbg_state); end
        @(negedge clk); rst = 1'b1;
        mode = 3'b011; p_data = 8'hB3; tick();
        total++; if (Q !== 8'hB3) begin bad++; $display("FAIL reset_load: got %h want b3", Q); end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Q !== 8'hB3 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_hold_b3[%0d]: q=%h busy=%b done=%b want b3 0 0", i, Q, busy, done); end
        end
    endtask

    task automatic test_direct_ops();
        logic [2:0] ops [7];
        logic       sls [7];
        logic [7:0] exp [7];
        ops = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        sls = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
        exp = '{8'hD9,  8'h59,  8'h66,  8'hD9,  8'h67,  8'hD9,  8'h00};
        for (int i = 0; i < 7; i++) begin
            load(8'hB3);
            mode = ops[i]; sin_left = sls[i]; sin_right = 1'b0;
            tick();
            total++; if (Q !== exp[i]) begin bad++; $display("FAIL direct_op[%0d] mode=%b: got %h want %h", i, ops[i], Q, exp[i]); end
            total++; if (sout_left !== exp[i][7] || sout_right !== exp[i][0]) begin bad++; $display("FAIL direct_sout[%0d]: got %b%b want %b%b", i, sout_left, sout_right, exp[i][7], exp[i][0]); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL direct_busy[%0d]: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_burst_rotate();
        logic [7:0] exp [3];
        exp = '{8'h67, 8'hCE, 8'h9D};
        load(8'hB3);
        start = 1'b1; mode = 3'b101; count = 4'd3;
        tick();
        total++; if (Q !== 8'hB3 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL burst_e0: q=%h busy=%b done=%b want b3 1 0", Q, busy, done); end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Q !== exp[i]) begin bad++; $display("FAIL burst_step[%0d]: got %h want %h", i, Q, exp[i]); end
            total++; if (busy !== (i < 2) || done !== (i == 2)) begin bad++; $display("FAIL burst_flags[%0d]: busy=%b done=%b", i, busy, done); end
        end
        tick();
        total++; if (done !== 1'b0 || Q !== 8'h9D) begin bad++; $display("FAIL burst_after: done=%b q=%h want 0 9d", done, Q); end
    endtask

    task automatic test_asr_ignore();
        logic [7:0] exp [4];
        exp = '{8'hC0, 8'hE0, 8'hF0, 8'hF8};
        load(8'h80);
        start = 1'b1; mode = 3'b110; count = 4'd4;
        tick();
        mode = 3'b011; p_data = 8'h00; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (Q !== exp[i]) begin bad++; $display("FAIL asr_step[%0d]: got %h want %h", i, Q, exp[i]); end
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL asr_done: done=%b busy=%b want 1 0", done, busy); end
        tick();
        total++; if (Q !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL asr_postload: q=%h done=%b want 00 0", Q, done); end
        drive_idle();
    endtask

    task automatic test_ignored_start();
        load(8'hB3);
        start = 1'b1; count = 4'd0; mode = 3'b010; sin_right = 1'b1;
        tick();
        total++; if (Q !== 8'h67 || busy !== 1'b0) begin bad++; $display("FAIL start_cnt0: q=%h busy=%b want 67 0", Q, busy); end
        start = 1'b1; count = 4'd5; mode = 3'b011; p_data = 8'h5A;
        tick();
        total++; if (Q !== 8'h5A || busy !== 1'b0) begin bad++; $display("FAIL start_load: q=%h busy=%b want 5a 0", Q, busy); end
        drive_idle();
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL start_nodone: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_rotate_full();
        logic [7:0] v;
        v = 8'($urandom_range(1, 254));
        load(v);
        start = 1'b1; mode = 3'b101; count = 4'd8;
        tick(); drive_idle();
        for (int i = 0; i < 8; i++) tick();
        total++; if (Q !== v || done !== 1'b1) begin bad++; $display("FAIL rotate_full: q=%h done=%b want %h 1", Q, done, v); end
        // Burst longer than N.
        start = 1'b1; mode = 3'b100; count = 4'd15;
        tick(); drive_idle();
        for (int i = 0; i < 15; i++) tick();
        total++; if (Q !== 8'(m_q) || done !== 1'b1) begin bad++; $display("FAIL rotate_15: q=%h done=%b want %h 1", Q, done, 8'(m_q)); end
    endtask

    task automatic test_back_to_back();
        load(8'hB3);
        start = 1'b1; mode = 3'b100; count = 4'd2;
        tick(); drive_idle();
        tick(); tick();
        total++; if (done !== 1'b1 || Q !== 8'hEC) begin bad++; $display("FAIL b2b_first: done=%b q=%h want 1 ec", done, Q); end
        start = 1'b1; mode = 3'b010; count = 4'd1; sin_right = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || done !== 1'b0 || Q !== 8'hEC) begin bad++; $display("FAIL b2b_e0: busy=%b done=%b q=%h want 1 0 ec", busy, done, Q); end
        start = 1'b0; mode = 3'b000;
        tick();
        total++; if (Q !== 8'hD9 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_second: q=%h done=%b busy=%b want d9 1 0", Q, done, busy); end
        drive_idle();
    endtask

    task automatic test_abort();
        load(8'hB3);
        start = 1'b1; mode = 3'b100; count = 4'd10;
        tick(); drive_idle();
        tick(); tick();
        total++; if (Q !== 8'hEC || busy !== 1'b1) begin bad++; $display("FAIL abort_pre: q=%h busy=%b want ec 1", Q, busy); end
        #2; rst = 1'b0; model_reset();
        #1;
        total++; if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 1'b0) begin bad++; $display("FAIL abort_async: q=%h busy=%b done=%b st=%b want 00 0 0 0", Q, busy, done, dbg_state); end
        tick();
        @(negedge clk); rst = 1'b1;
        mode = 3'b011; p_data = 8'h3C;
        tick();
        total++; if (Q !== 8'h3C || busy !== 1'b0) begin bad++; $display("FAIL abort_reload: q=%h busy=%b want 3c 0", Q, busy); end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            mode      = 3'($urandom_range(0, 7));
            p_data    = 8'($urandom);
            sin_left  = 1'($urandom);
            sin_right = 1'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            count     = 4'($urandom_range(0, 15));
            tick();
            total++; if (Q !== 8'(m_q)) begin bad++; $display("FAIL rand_q[%0d]: got %h want %h", i, Q, 8'(m_q)); end
            total++; if (busy !== m_busy || done !== m_done) begin bad++; $display("FAIL rand_flags[%0d]: busy=%b done=%b want %b %b", i, busy, done, m_busy, m_done); end
        end
        drive_idle();
    endtask

    initial begin
        total = 0; bad = 0;
        model_reset();
        test_reset();
        test_direct_ops();
        test_burst_rotate();
        test_asr_ignore();
        test_ignored_start();
        test_rotate_full();
        test_back_to_back();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
